hazard_stall_unit: RTL and testbench

Generates the stall and flush controls consumed by the program counter and the IF/ID and ID/EX pipeline registers in the 5-stage MIPS datapath. It detects load-use hazards combinationally in ID. It also runs a small state machine that holds fetch for a fixed number of cycles after a branch/jump decodes, until the branch target is resolved downstream. `PCHold` connects directly to the PC's hold input, where 1 means keep the current address.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/stall_counter.sv | 27 ++
 rtl/hazard_stall_unit.sv | 108 ++++++++++
 tb/tb_hazard_stall_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types and constants for the hazard/stall logic.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StBrStall = 2'b01
    } state_e;

    localparam logic [4:0]  REG_ZERO                = 5'd0;
    localparam int unsigned BRANCH_STALL_CYCLES_DEF = 2;

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter; done flags the last held cycle. Saturates at 1 so it never wraps.
module stall_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q > WIDTH'(1))) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and branch stall/flush control for the 5-stage pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned BRANCH_STALL_CYCLES = BRANCH_STALL_CYCLES_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic       ID_Branch,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_Rt,
    output logic       PCHold,
    output logic       IFIDHold,
    output logic       IFIDFlush,
    output logic       IDEXBubble,
    output logic [1:0] debug_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_luh_cnt,
    output logic [31:0] perf_br_cnt
`endif
);

    localparam int unsigned      CntW      = $clog2(BRANCH_STALL_CYCLES + 1);
    localparam logic [CntW-1:0]  StallLoad = CntW'(BRANCH_STALL_CYCLES);

    state_e state_q;
    logic   br_q;
    logic   luh;
    logic   run;
    logic   in_br;
    logic   cnt_load;
    logic   cnt_done;

    // Qualified by Reset so the Mealy stall outputs are quiet during reset.
    assign luh = Reset && IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                 ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    assign run      = (state_q == StRun);
    assign in_br    = (state_q == StBrStall);
    assign cnt_load = run && !luh && ID_Branch;

    stall_counter #(
        .WIDTH(CntW)
    ) u_br_cnt (
        .clk     (Clk),
        .rst_n   (Reset),
        .load    (cnt_load),
        .load_val(StallLoad),
        .dec     (in_br),
        .done    (cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StRun;
            br_q    <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (cnt_load) begin
                        state_q <= StBrStall;
                        br_q    <= 1'b1;
                    end
                end
                StBrStall: begin
                    if (cnt_done) begin
                        state_q <= StRun;
                        br_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StRun;
                    br_q    <= 1'b0;
                end
            endcase
        end
    end

    assign PCHold      = (run && luh) || br_q;
    assign IFIDHold    = run && luh;
    assign IDEXBubble  = run && luh;
    assign IFIDFlush   = br_q;
    assign debug_state = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_luh_q;
    logic [31:0] perf_br_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            perf_luh_q <= '0;
            perf_br_q  <= '0;
        end else begin
            if (run && luh) perf_luh_q <= perf_luh_q + 32'd1;
            if (in_br)      perf_br_q  <= perf_br_q + 32'd1;
        end
    end

    assign perf_luh_cnt = perf_luh_q;
    assign perf_br_cnt  = perf_br_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver queues expected outputs, monitor checks them.
module tb_hazard_stall_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
    logic       IFID_UsesRt, ID_Branch, IDEX_MemRead;
    logic       PCHold, IFIDHold, IFIDFlush, IDEXBubble;
    logic [1:0] debug_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_luh_cnt, perf_br_cnt;
`endif

    hazard_stall_unit #(
        .BRANCH_STALL_CYCLES(2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IFID_Rs     (IFID_Rs),
        .IFID_Rt     (IFID_Rt),
        .IFID_UsesRt (IFID_UsesRt),
        .ID_Branch   (ID_Branch),
        .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt     (IDEX_Rt),
        .PCHold      (PCHold),
        .IFIDHold    (IFIDHold),
        .IFIDFlush   (IFIDFlush),
        .IDEXBubble  (IDEXBubble),
        .debug_state (debug_state)
`ifdef HAZARD_PERF_EN
        ,
        .perf_luh_cnt(perf_luh_cnt),
        .perf_br_cnt (perf_br_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected vector: {PCHold, IFIDHold, IFIDFlush, IDEXBubble, debug_state}
    localparam logic [5:0] E_IDLE = 6'b0000_00;
    localparam logic [5:0] E_LUH  = 6'b1101_00;
    localparam logic [5:0] E_BR   = 6'b1010_01;

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic br, input logic memrd,
                        input logic [4:0] exrt, input logic [5:0] exp, input string name);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset        = rst;
        IFID_Rs      = rs;
        IFID_Rt      = rt;
        IFID_UsesRt  = uses_rt;
        ID_Branch    = br;
        IDEX_MemRead = memrd;
        IDEX_Rt      = exrt;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic quiet(input logic [5:0] exp, input string name);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, exp, name);
    endtask

    // Monitor: every cycle presents an output, compare mid-cycle on the falling edge.
    initial begin
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PCHold, IFIDHold, IFIDFlush, IDEXBubble, debug_state};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        Reset = 1'b0; IFID_Rs = 5'd8; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        ID_Branch = 1'b0; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8;

        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, E_IDLE, "reset0");
        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, E_IDLE, "reset1");
        quiet(E_IDLE, "idle");
        step(1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, E_LUH, "luh_rt");
        quiet(E_IDLE, "luh_clear");
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, E_IDLE, "zero_reg");
        step(1'b1, 5'd12, 5'd5, 1'b0, 1'b0, 1'b1, 5'd12, E_LUH, "luh_rs");
        step(1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, E_IDLE, "rt_unused");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, E_IDLE, "br_issue");
        quiet(E_BR, "br_stall1");
        // hazard and branch inputs are ignored while stalling
        step(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, E_BR, "br_stall2");
        quiet(E_IDLE, "br_resume");
        step(1'b1, 5'd6, 5'd2, 1'b0, 1'b1, 1'b1, 5'd6, E_LUH, "prec_luh");
        step(1'b1, 5'd6, 5'd2, 1'b0, 1'b1, 1'b0, 5'd6, E_IDLE, "prec_br");
        quiet(E_BR, "prec_stall1");
        quiet(E_BR, "prec_stall2");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, E_IDLE, "b2b_run");
        quiet(E_BR, "b2b_stall1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, E_BR, "rst_mid_pre");
        quiet(E_IDLE, "rst_mid_post");
        quiet(E_IDLE, "no_residual");

`ifdef HAZARD_PERF_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, E_LUH, "perf_luh");
            quiet(E_IDLE, "perf_luh_gap");
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, E_IDLE, "perf_br");
            quiet(E_BR, "perf_br_s1");
            quiet(E_BR, "perf_br_s2");
            quiet(E_IDLE, "perf_br_end");
        end
        @(negedge Clk);
        checks++;
        if (perf_luh_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_luh_cnt: got %0d expected 3", perf_luh_cnt);
        end
        checks++;
        if (perf_br_cnt !== 32'd4) begin
            errors++;
            $display("FAIL perf_br_cnt: got %0d expected 4", perf_br_cnt);
        end
`endif

        repeat (3) @(negedge Clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
